// File: rtl/rf_wr_arb_pkg.sv
// Shared widths and grant encodings for the register-file write-port arbiter.
package rf_wr_arb_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 3;

    localparam logic GNT_REQ0 = 1'b0;
    localparam logic GNT_REQ1 = 1'b1;

endpackage

// File: rtl/rf_wr_arb_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a conflict goes to
// the requester that was not granted last. Purely combinational.
module rr_arb2
    import rf_wr_arb_pkg::*;
(
    input  logic [1:0] reqValid,
    input  logic       stall,
    input  logic       lastGnt,
    output logic [1:0] gnt
);

    logic conflict;

    assign conflict = reqValid[0] & reqValid[1];

    always_comb begin
        // NOTE: default every output first so no path through this block infers a latch.
        gnt = 2'b00;
        if (!stall) begin
            if (conflict) begin
                gnt[0] = (lastGnt == GNT_REQ1);
                gnt[1] = (lastGnt == GNT_REQ0);
            end else begin
                gnt = reqValid;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arb.sv
// Arbitrates the single register-file write port between writeback (req0) and
// the multicycle unit (req1); the winning write is registered onto wr_*.
module rf_wr_arb
    import rf_wr_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              last_gnt
);

    logic [1:0] gnt;
    logic       xfer;

    rr_arb2 uArb (
        .reqValid ({req1_valid, req0_valid}),
        .stall    (stall),
        .lastGnt  (last_gnt),
        .gnt      (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    assign xfer       = |gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            last_gnt <= GNT_REQ1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            wr_en <= xfer;
            if (xfer) begin
                wr_addr  <= gnt[1] ? req1_addr : req0_addr;
                wr_data  <= gnt[1] ? req1_data : req0_data;
                last_gnt <= gnt[1] ? GNT_REQ1 : GNT_REQ0;
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed self-checking bench for rf_wr_arb with a small regfile model.
module tb_rf_wr_arb;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          last_gnt;

    logic [DW-1:0] rfModel [8];

    int nCompared = 0;
    int nMismatch = 0;

    rf_wr_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .last_gnt   (last_gnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) rfModel[wr_addr] <= wr_data;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatch++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge, leaving time before the following one.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkWr(input string tag, input logic en, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic g);
        check({tag, "_wr_en"}, 32'(wr_en), 32'(en));
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'(a));
        check({tag, "_wr_data"}, 32'(wr_data), 32'(d));
        check({tag, "_last_gnt"}, 32'(last_gnt), 32'(g));
    endtask

    task automatic checkReady(input string tag, input logic r0, input logic r1);
        check({tag, "_req0_ready"}, 32'(req0_ready), 32'(r0));
        check({tag, "_req1_ready"}, 32'(req1_ready), 32'(r1));
    endtask

    initial begin
        logic [DW-1:0] d0, d1, expData;
        logic [AW-1:0] expAddr;
        logic          expG;

        for (int i = 0; i < 8; i++) rfModel[i] = '0;
        rst = 1'b0; stall = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        #12;
        checkWr("por", 1'b0, 3'd0, 16'h0000, 1'b1);
        tick();
        rst = 1'b1;

        // Single requester
        tick();
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'hBEEF;
        #1 checkReady("single", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        checkWr("single_w", 1'b1, 3'd3, 16'hBEEF, 1'b0);
        tick();
        checkWr("single_idle", 1'b0, 3'd3, 16'hBEEF, 1'b0);

        // Mid-run reset while a write is on the port
        req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 16'h6666;
        tick();
        req1_valid = 1'b0;
        checkWr("pre_rst", 1'b1, 3'd6, 16'h6666, 1'b1);
        #1 rst = 1'b0;
        #1 checkWr("async_rst", 1'b0, 3'd0, 16'h0000, 1'b1);
        #1 rst = 1'b1;

        // Conflict after reset: req0 first
        tick();
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h2222;
        #1 checkReady("conf_a", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        checkWr("conf_w0", 1'b1, 3'd1, 16'h1111, 1'b0);
        #1 checkReady("conf_b", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        checkWr("conf_w1", 1'b1, 3'd2, 16'h2222, 1'b1);
        tick();
        check("conf_idle_wr_en", 32'(wr_en), 32'd0);

        // Fairness: strict alternation starting with req0 (last_gnt=1)
        d0 = 16'hA000; d1 = 16'hB000;
        req0_valid = 1'b1; req0_addr = 3'd4; req0_data = d0;
        req1_valid = 1'b1; req1_addr = 3'd7; req1_data = d1;
        for (int i = 0; i < 6; i++) begin
            expG = i[0];
            #1 checkReady($sformatf("fair%0d", i), ~expG, expG);
            expData = expG ? d1 : d0;
            expAddr = expG ? 3'd7 : 3'd4;
            tick();
            if (expG) begin d1 = d1 + 16'h0001; req1_data = d1; end
            else      begin d0 = d0 + 16'h0001; req0_data = d0; end
            checkWr($sformatf("fair%0d", i), 1'b1, expAddr, expData, expG);
        end

        // Stall with both valid; last write was req1 (addr 7, B002)
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 checkReady($sformatf("stall%0d", i), 1'b0, 1'b0);
            tick();
            checkWr($sformatf("stall%0d", i), 1'b0, 3'd7, 16'hB002, 1'b1);
        end
        stall = 1'b0;
        #1 checkReady("unstall", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checkWr("unstall", 1'b1, 3'd4, 16'hA003, 1'b0);

        // Same address, last_gnt=0 -> req1 first, req0 lands last
        req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'h5555;
        #1 checkReady("same_a", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        checkWr("same_w1", 1'b1, 3'd5, 16'h5555, 1'b1);
        #1 checkReady("same_b", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        checkWr("same_w0", 1'b1, 3'd5, 16'hAAAA, 1'b0);
        tick();
        check("same_idle_wr_en", 32'(wr_en), 32'd0);
        check("same_r5", 32'(rfModel[5]), 32'h0000AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
